// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared types, kernel weights and width helper for the Sobel filter
package sobel_pkg;

  typedef enum logic [1:0] {
    MAG_L1  = 2'd0,
    MAG_GX  = 2'd1,
    MAG_GY  = 2'd2,
    MAG_MAX = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam int K_SIDE   = 1;
  localparam int K_CENTRE = 2;

  // Gradient sums of 4*(2^P-1) on each side need two extra magnitude bits plus sign.
  function automatic int grad_w(input int pxl_w);
    return pxl_w + 3;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// rtl/sobel_line_buffer.sv - one-line circular pixel store, read-before-write by column
module sobel_line_buffer #(
  parameter int DEPTH = 5,
  parameter int W     = 8,
  parameter int AW    = 3
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  data_o
);

  logic [W-1:0] mem_q [DEPTH];

  assign data_o = mem_q[addr_i];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      mem_q[addr_i] <= data_i;
    end
  end

endmodule

// File: rtl/sobel_conv_stream.sv
// rtl/sobel_conv_stream.sv - streaming 3x3 Sobel filter with frame sync, mode select and saturation
module sobel_conv_stream
  import sobel_pkg::*;
#(
  parameter int PXL_W = 8,
  parameter int IMG_W = 5,
  parameter int IMG_H = 5,
  parameter int OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PXL_W-1:0]        pxl_in,
  input  logic                    pxl_in_valid,
  input  logic                    sof_in,
  input  logic [1:0]              mode,
  output logic [OUT_W-1:0]        pxl_out,
  output logic signed [PXL_W+2:0] gx_out,
  output logic signed [PXL_W+2:0] gy_out,
  output logic                    valid,
  output logic                    eof_out,
  output logic                    busy
);

  localparam int GW = grad_w(PXL_W);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int MW = (GW > OUT_W) ? GW : OUT_W;
  localparam logic [MW-1:0] SAT_MAX = MW'({OUT_W{1'b1}});

  state_e state_q, state_d;
  mode_e  mode_q, mode_d, cur_mode, win_mode_q;
  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic take, last_col, last_pix, complete;

  logic [PXL_W-1:0] lb0_out, lb1_out;
  logic [PXL_W-1:0] win_q [3][3];
  logic             win_v_q, win_eof_q;

  logic [GW-1:0]        right_c, left_c, bot_c, top_c, ax_c, ay_c, mag_c;
  logic signed [GW-1:0] gx_c, gy_c;
  logic [MW-1:0]        mag_ext;
  logic [OUT_W-1:0]     mag_sat;

  logic                 s1_v_q, s1_eof_q;
  logic signed [GW-1:0] s1_gx_q, s1_gy_q;
  logic [OUT_W-1:0]     s1_mag_q;

  // An accepted sof forces this pixel to (0,0) regardless of where the counters are.
  always_comb begin
    take     = pxl_in_valid && (sof_in || (state_q == ACTIVE));
    cur_col  = sof_in ? '0 : col_q;
    cur_row  = sof_in ? '0 : row_q;
    cur_mode = sof_in ? mode_e'(mode) : mode_q;
    last_col = (cur_col == CW'(IMG_W - 1));
    last_pix = last_col && (cur_row == RW'(IMG_H - 1));
    complete = take && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    mode_d   = mode_q;
    if (take) begin
      mode_d = cur_mode;
      if (last_pix) begin
        state_d = DONE;
        col_d   = '0;
        row_d   = '0;
      end else begin
        state_d = ACTIVE;
        col_d   = last_col ? '0 : cur_col + 1'b1;
        row_d   = last_col ? cur_row + 1'b1 : cur_row;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      mode_q  <= MAG_L1;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      mode_q  <= mode_d;
    end
  end

  assign busy = (state_q == ACTIVE);

  sobel_line_buffer #(.DEPTH(IMG_W), .W(PXL_W), .AW(CW)) u_lb0 (
    .clk_i(clk), .en_i(take), .addr_i(cur_col), .data_i(pxl_in), .data_o(lb0_out)
  );

  sobel_line_buffer #(.DEPTH(IMG_W), .W(PXL_W), .AW(CW)) u_lb1 (
    .clk_i(clk), .en_i(take), .addr_i(cur_col), .data_i(lb0_out), .data_o(lb1_out)
  );

  // Row 0 of the window is the oldest line, column 2 the newest pixel.
  always_ff @(posedge clk) begin
    if (take) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2] <= lb1_out;
      win_q[1][2] <= lb0_out;
      win_q[2][2] <= pxl_in;
    end
  end

  always_comb begin
    right_c = GW'(win_q[0][2]) * GW'(K_SIDE) + GW'(win_q[1][2]) * GW'(K_CENTRE) + GW'(win_q[2][2]) * GW'(K_SIDE);
    left_c  = GW'(win_q[0][0]) * GW'(K_SIDE) + GW'(win_q[1][0]) * GW'(K_CENTRE) + GW'(win_q[2][0]) * GW'(K_SIDE);
    bot_c   = GW'(win_q[2][0]) * GW'(K_SIDE) + GW'(win_q[2][1]) * GW'(K_CENTRE) + GW'(win_q[2][2]) * GW'(K_SIDE);
    top_c   = GW'(win_q[0][0]) * GW'(K_SIDE) + GW'(win_q[0][1]) * GW'(K_CENTRE) + GW'(win_q[0][2]) * GW'(K_SIDE);
    gx_c    = right_c - left_c;
    gy_c    = bot_c - top_c;
    ax_c    = gx_c[GW-1] ? -gx_c : gx_c;
    ay_c    = gy_c[GW-1] ? -gy_c : gy_c;
    case (win_mode_q)
      MAG_GX:  mag_c = ax_c;
      MAG_GY:  mag_c = ay_c;
      MAG_MAX: mag_c = (ax_c > ay_c) ? ax_c : ay_c;
      default: mag_c = ax_c + ay_c;
    endcase
    mag_ext = MW'(mag_c);
    mag_sat = (mag_ext > SAT_MAX) ? {OUT_W{1'b1}} : mag_ext[OUT_W-1:0];
  end

  // Window -> gradient stage -> output stage; data registers hold while their valid is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_v_q    <= 1'b0;
      win_eof_q  <= 1'b0;
      win_mode_q <= MAG_L1;
      s1_v_q     <= 1'b0;
      s1_eof_q   <= 1'b0;
      s1_gx_q    <= '0;
      s1_gy_q    <= '0;
      s1_mag_q   <= '0;
      valid      <= 1'b0;
      eof_out    <= 1'b0;
      gx_out     <= '0;
      gy_out     <= '0;
      pxl_out    <= '0;
    end else begin
      win_v_q   <= complete;
      win_eof_q <= complete && last_pix;
      if (take) begin
        win_mode_q <= cur_mode;
      end
      s1_v_q   <= win_v_q;
      s1_eof_q <= win_eof_q;
      if (win_v_q) begin
        s1_gx_q  <= gx_c;
        s1_gy_q  <= gy_c;
        s1_mag_q <= mag_sat;
      end
      valid   <= s1_v_q;
      eof_out <= s1_v_q && s1_eof_q;
      if (s1_v_q) begin
        gx_out  <= s1_gx_q;
        gy_out  <= s1_gy_q;
        pxl_out <= s1_mag_q;
      end
    end
  end

endmodule
